// File: rtl/pkt_checksum_arbiter.sv
// rtl/pkt_checksum_arbiter.sv - round-robin packet arbiter in front of a shared checksum engine with in-order result return
module pkt_checksum_arbiter #(
   parameter int NUM_REQ          = 4,
   parameter int AXIS_BUS_WIDTH   = 64,
   parameter int AXIS_TUSER_WIDTH = 4,
   parameter int RES_DEPTH        = 4
) (
   input  logic                                   aclk,
   input  logic                                   areset,
   input  logic [NUM_REQ*AXIS_BUS_WIDTH-1:0]      s_axis_tdata,
   input  logic [NUM_REQ*(AXIS_BUS_WIDTH/8)-1:0]  s_axis_tkeep,
   input  logic [NUM_REQ*AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic [NUM_REQ-1:0]                     s_axis_tlast,
   input  logic [NUM_REQ-1:0]                     s_axis_tvalid,
   output logic [NUM_REQ-1:0]                     s_axis_tready,
   input  logic [NUM_REQ-1:0]                     s_is_tagged,
   output logic [AXIS_BUS_WIDTH-1:0]              m_axis_tdata,
   output logic [AXIS_BUS_WIDTH/8-1:0]            m_axis_tkeep,
   output logic [AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
   output logic                                   m_axis_tlast,
   output logic                                   m_axis_tvalid,
   input  logic                                   m_axis_tready,
   output logic                                   m_is_tagged,
   input  logic [15:0]                            chk_in,
   input  logic                                   chk_in_valid,
   output logic [15:0]                            res_checksum,
   output logic [$clog2(NUM_REQ)-1:0]             res_id,
   output logic                                   res_valid,
   input  logic                                   res_ready,
   output logic                                   err_orphan
);

   localparam int KW  = AXIS_BUS_WIDTH / 8;
   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = $clog2(RES_DEPTH);
   localparam int CW  = PW + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic           tag_q, tag_d;

   // id FIFO remembers which requester owns each packet inside the engine
   logic [IDW-1:0] id_mem [RES_DEPTH];
   logic [PW-1:0]  id_wr_q, id_rd_q;
   logic [CW-1:0]  id_cnt_q;

   // result FIFO holds {id, checksum} until the consumer takes it
   logic [IDW+15:0] res_mem [RES_DEPTH];
   logic [PW-1:0]   res_wr_q, res_rd_q;
   logic [CW-1:0]   res_cnt_q;
   logic            err_q;

   logic [CW:0]    outstanding;
   logic           can_grant;
   logic [IDW-1:0] pick;
   logic           pick_found;
   logic [IDW:0]   idx;
   logic           grant_fire, last_beat;
   logic           id_push, id_pop, res_push, res_pop;

   assign outstanding = {1'b0, id_cnt_q} + {1'b0, res_cnt_q};
   assign can_grant   = outstanding < (CW+1)'(RES_DEPTH);
   assign grant_fire  = (state_q == IDLE) && pick_found && can_grant;
   assign last_beat   = (state_q == BUSY) && s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q];
   assign id_push     = grant_fire;
   assign id_pop      = chk_in_valid && (id_cnt_q != '0);
   assign res_push    = id_pop;
   assign res_pop     = (res_cnt_q != '0) && res_ready;

   assign res_valid                = (res_cnt_q != '0) && !areset;
   assign {res_id, res_checksum}   = res_mem[res_rd_q];
   assign m_is_tagged              = tag_q;
   assign err_orphan               = err_q;

   // round-robin search: first valid requester at or after rr_ptr, wrapping
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      idx        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
         if (!pick_found && s_axis_tvalid[idx[IDW-1:0]]) begin
            pick       = idx[IDW-1:0];
            pick_found = 1'b1;
         end
      end
   end

   // next-state logic and stream routing; outputs are forced quiet while in reset
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      tag_d         = tag_q;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = s_axis_tdata[int'(grant_q)*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KW +: KW];
      m_axis_tuser  = s_axis_tuser[int'(grant_q)*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
      m_axis_tlast  = s_axis_tlast[grant_q];
      case (state_q)
         IDLE: begin
            if (grant_fire) begin
               grant_d = pick;
               tag_d   = s_is_tagged[pick];
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!areset) begin
               m_axis_tvalid          = s_axis_tvalid[grant_q];
               s_axis_tready[grant_q] = m_axis_tready;
            end
            if (last_beat) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // arbiter state register
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         tag_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         tag_q    <= tag_d;
      end
   end

   // FIFO pointers, occupancy and the sticky orphan flag
   always_ff @(posedge aclk) begin
      if (areset) begin
         id_wr_q   <= '0;
         id_rd_q   <= '0;
         id_cnt_q  <= '0;
         res_wr_q  <= '0;
         res_rd_q  <= '0;
         res_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (id_push)  id_wr_q  <= id_wr_q + 1'b1;
         if (id_pop)   id_rd_q  <= id_rd_q + 1'b1;
         if (res_push) res_wr_q <= res_wr_q + 1'b1;
         if (res_pop)  res_rd_q <= res_rd_q + 1'b1;
         case ({id_push, id_pop})
            2'b10:   id_cnt_q <= id_cnt_q + 1'b1;
            2'b01:   id_cnt_q <= id_cnt_q - 1'b1;
            default: id_cnt_q <= id_cnt_q;
         endcase
         case ({res_push, res_pop})
            2'b10:   res_cnt_q <= res_cnt_q + 1'b1;
            2'b01:   res_cnt_q <= res_cnt_q - 1'b1;
            default: res_cnt_q <= res_cnt_q;
         endcase
         if (chk_in_valid && (id_cnt_q == '0)) err_q <= 1'b1;
      end
   end

   // FIFO storage needs no reset; occupancy counters qualify every read
   always_ff @(posedge aclk) begin
      if (id_push)  id_mem[id_wr_q]   <= pick;
      if (res_push) res_mem[res_wr_q] <= {id_mem[id_rd_q], chk_in};
   end

endmodule

// File: doc/pkt_checksum_arbiter.md
PKT_CHECKSUM_ARBITER -- requirements
Module: pkt_checksum_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of ingress AXI-Stream requesters, range 2..8.
REQ-002 SHALL have parameter AXIS_BUS_WIDTH, default 64: tdata width; tkeep width is AXIS_BUS_WIDTH/8.
REQ-003 SHALL have parameter AXIS_TUSER_WIDTH, default 4: tuser width.
REQ-004 SHALL have parameter RES_DEPTH, default 4: result FIFO depth and maximum packets outstanding, power of 2.
REQ-005 SHALL use one clock with a synchronous, active-high reset; all state samples on the rising edge of aclk.
REQ-006 SHALL have port aclk, input, 1: clock.
REQ-007 SHALL have port areset, input, 1: reset.
REQ-008 SHALL have ports s_axis_tdata/tkeep/tuser/tlast/tvalid, input, NUM_REQ x (AXIS_BUS_WIDTH/AXIS_BUS_WIDTH/8/AXIS_TUSER_WIDTH/1/1), flattened: requester streams.
REQ-009 SHALL have port s_axis_tready, output, NUM_REQ: per-requester ready.
REQ-010 SHALL have port s_is_tagged, input, NUM_REQ: per-requester VLAN-tag flag, valid with first beat.
REQ-011 SHALL have ports m_axis_tdata/tkeep/tuser/tlast/tvalid, output, widths as one requester: stream to shared checksum engine.
REQ-012 SHALL have port m_axis_tready, input, 1: engine ready.
REQ-013 SHALL have port m_is_tagged, output, 1: tag flag of granted requester, held for whole packet.
REQ-014 SHALL have ports chk_in (input, 16) and chk_in_valid (input, 1): engine checksum result, one pulse per packet.
REQ-015 SHALL have ports res_checksum (output, 16), res_id (output, clog2(NUM_REQ)), res_valid (output, 1), res_ready (input, 1): result stream.
REQ-016 SHALL have port err_orphan, output, 1: sticky flag, result received with no packet outstanding.

Function
REQ-017 SHALL implement states IDLE and BUSY; reset state IDLE.
REQ-018 In IDLE, with any s_axis_tvalid high and outstanding < RES_DEPTH, SHALL register grant = first valid requester at or after rr_ptr (round-robin, wrapping) and enter BUSY next cycle.
REQ-019 In IDLE, SHALL drive all s_axis_tready and m_axis_tvalid low; arbitration latency is exactly 1 cycle.
REQ-020 In BUSY, SHALL route granted requester's tdata/tkeep/tuser/tlast/tvalid to m_axis combinationally and m_axis_tready to its s_axis_tready only; all other tready low.
REQ-021 SHALL latch m_is_tagged from s_is_tagged[grant] at grant and hold it until return to IDLE.
REQ-022 On m_axis tvalid&tready&tlast in BUSY, SHALL return to IDLE and set rr_ptr = grant+1 mod NUM_REQ; no packet interleaving or mid-packet grant change.
REQ-023 SHALL push grant id into an internal id FIFO (depth RES_DEPTH) at the grant cycle.
REQ-024 SHALL keep outstanding = id FIFO count + result FIFO count; +1 on grant, -1 on result pop (res_valid&res_ready); unchanged when both occur in the same cycle.
REQ-025 SHALL not grant when outstanding == RES_DEPTH; arbitration resumes the cycle after a result pop makes outstanding < RES_DEPTH.
REQ-026 On chk_in_valid with id FIFO non-empty, SHALL pop the id FIFO and push {id, chk_in} into the result FIFO; result FIFO cannot overflow by REQ-025.
REQ-027 On chk_in_valid with id FIFO empty, SHALL discard chk_in and set err_orphan until reset.
REQ-028 Result FIFO SHALL be first-word-fall-through: res_valid high when non-empty; a push into an empty FIFO is visible on res_valid the next cycle.
REQ-029 Simultaneous push and pop on either FIFO SHALL be legal, including when full (result FIFO) or empty (push-through takes 1 cycle).
REQ-030 Pointers SHALL wrap modulo RES_DEPTH; counts are clog2(RES_DEPTH)+1 bits.

Reset
REQ-031 On areset SHALL go to IDLE, rr_ptr=0, grant=0, both FIFOs empty, outstanding=0, err_orphan=0, m_is_tagged=0.
REQ-032 During and the cycle after reset, all s_axis_tready, m_axis_tvalid, res_valid SHALL be 0; reset mid-packet drops the packet and its pending result.

Verification
REQ-033 Requesters 0 and 2 valid with 3-beat packets, rr_ptr=0 -> req 0 granted cycle 1, beats out cycles 1-3, req 2 granted at cycle 4 (1-cycle gap), rr_ptr=3 after.
REQ-034 All 4 requesters continuously valid, m_axis_tready=1, results returned immediately and res_ready=1 -> grant order 0,1,2,3,0; no starvation.
REQ-035 res_ready=0, RES_DEPTH=4, 5 packets offered -> 4 granted, 5th held with tready=0; one res pop -> 5th granted next IDLE cycle.
REQ-036 Req 1 tagged (s_is_tagged[1]=1) packet, chk_in=0xBEEF -> m_is_tagged=1 throughout packet; res_id=1, res_checksum=0xBEEF.
REQ-037 chk_in_valid pulse with no packet outstanding -> no result push, err_orphan=1 sticky until areset.
REQ-038 areset asserted on 2nd of 4 beats -> next cycle IDLE, all readies 0, outstanding=0, res_valid=0.
